// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared constants and FSM state type for the line-delay controller
package line_buf_pkg;
  localparam int LB_ADDR_WIDTH = 11;
  localparam int LB_DATA_WIDTH = 9;
  typedef enum logic [1:0] {WAIT_FRAME, FIRST_LINE, LINES} lb_state_e;
endpackage

// File: rtl/line_buf_ctrl_sig_edge.sv
// sig_edge: single-cycle rising or falling edge detector
module sig_edge #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic hit_o
);
  logic sig_q;
  always_ff @(posedge clk) sig_q <= rst ? 1'b0 : sig_i;
  assign hit_o = RISING ? (sig_i & ~sig_q) : (~sig_i & sig_q);
endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: drives a 1-cycle-latency line RAM and pairs each pixel with the one above it
module line_buf_ctrl import line_buf_pkg::*; #(
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
  parameter int DATA_WIDTH = LB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vsync,
  input  logic                  in_de,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_clk_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_de,
  output logic [DATA_WIDTH-1:0] out_cur,
  output logic [DATA_WIDTH-1:0] out_prev,
  output logic                  out_prev_vld,
  output logic [ADDR_WIDTH:0]   line_len,
  output logic                  ovf
);
  localparam logic [ADDR_WIDTH:0] COL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  lb_state_e state_q, state_d;
  logic vs_rise, de_fall, accept, ovf_pix, rd_en;
  logic [ADDR_WIDTH:0] col_q, col_d, line_len_q, line_len_d;
  logic wr_en_q, out_de_q, prev_vld_q, ovf_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q, cur_q;

  sig_edge #(.RISING(1'b1)) u_vs_edge (.clk(clk), .rst(rst), .sig_i(in_vsync), .hit_o(vs_rise));
  sig_edge #(.RISING(1'b0)) u_de_edge (.clk(clk), .rst(rst), .sig_i(in_de), .hit_o(de_fall));

  // A vsync edge overrides everything: its pixel (if any) is column 0 of the first line
  always_comb begin
    accept = in_de && (vs_rise || state_q != WAIT_FRAME);
    ovf_pix = accept && !vs_rise && col_q == COL_MAX;
    rd_en = accept && !ovf_pix;
    ram_rd_clk_en = rd_en;
    ram_rd_addr = (rd_en && !vs_rise) ? col_q[ADDR_WIDTH-1:0] : '0;
    state_d = vs_rise ? FIRST_LINE : (state_q == FIRST_LINE && de_fall) ? LINES : state_q;
    col_d = vs_rise ? (ADDR_WIDTH+1)'(in_de) :
            (state_q == WAIT_FRAME) ? col_q :
            de_fall ? '0 :
            (accept && col_q != COL_MAX) ? col_q + 1'b1 : col_q;
    line_len_d = (!vs_rise && state_q != WAIT_FRAME && de_fall) ? col_q : line_len_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_FRAME;
      col_q      <= '0;
      line_len_q <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_de_q   <= 1'b0;
      cur_q      <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_len_q <= line_len_d;
      ovf_q      <= !vs_rise && (ovf_q || ovf_pix);
      wr_en_q    <= rd_en;
      wr_addr_q  <= ram_rd_addr;
      wr_data_q  <= in_data;
      out_de_q   <= accept;
      cur_q      <= in_data;
      prev_vld_q <= accept && !vs_rise && state_q == LINES && col_q < line_len_q;
    end
  end

  assign ram_wr_en    = wr_en_q;
  assign ram_wr_addr  = wr_addr_q;
  assign ram_wr_data  = wr_data_q;
  assign out_de       = out_de_q;
  assign out_cur      = cur_q;
  assign out_prev_vld = prev_vld_q;
  assign out_prev     = prev_vld_q ? ram_rd_data : '0;
  assign line_len     = line_len_q;
  assign ovf          = ovf_q;
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: table-driven check of line_buf_ctrl with an attached line RAM model
module tb_line_buf_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_vsync = 1'b0, in_de = 1'b0;
  logic [8:0] in_data = '0;
  logic ram_wr_en, ram_rd_clk_en, out_de, out_prev_vld, ovf;
  logic [10:0] ram_wr_addr, ram_rd_addr;
  logic [8:0] ram_wr_data, ram_rd_data = '0, out_cur, out_prev;
  logic [11:0] line_len;
  logic [8:0] mem [0:2047];
  int n_pass = 0, n_total = 0;

  typedef struct {
    logic vs, de;
    logic [8:0] d;
    logic rd;
    logic [10:0] ra;
    logic pv;
    logic [8:0] prev;
    logic [11:0] ln;
  } vec_t;
  vec_t tbl[$];

  line_buf_ctrl dut (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_de(in_de), .in_data(in_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_clk_en(ram_rd_clk_en), .ram_rd_data(ram_rd_data),
    .out_de(out_de), .out_cur(out_cur), .out_prev(out_prev), .out_prev_vld(out_prev_vld),
    .line_len(line_len), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_clk_en) ram_rd_data <= mem[ram_rd_addr];
  end

  function automatic vec_t v(logic vs, logic de, logic [8:0] d, logic rd, logic [10:0] ra,
                             logic pv, logic [8:0] prev, logic [11:0] ln);
    vec_t r;
    r.vs = vs; r.de = de; r.d = d; r.rd = rd; r.ra = ra; r.pv = pv; r.prev = prev; r.ln = ln;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set(logic vs, logic de, logic [8:0] d);
    in_vsync = vs; in_de = de; in_data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 9'h010 + 9'(i), 1, 11'(i), 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 4));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 9'h020 + 9'(i), 1, 11'(i), 1, 9'h010 + 9'(i), 4));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 4));
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(1, 1, 9'h030 + 9'(i), 1, 11'(i), i < 4, (i < 4) ? 9'h020 + 9'(i) : 9'h0, 4));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(v(0, 1, 9'h040, 1, 0, 1, 9'h030, 6));
    tbl.push_back(v(0, 1, 9'h041, 1, 1, 1, 9'h031, 6));
    tbl.push_back(v(1, 1, 9'h042, 1, 0, 0, 0, 6));
    tbl.push_back(v(1, 1, 9'h043, 1, 1, 0, 0, 6));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(v(1, 1, 9'h050, 1, 0, 1, 9'h042, 2));
    tbl.push_back(v(1, 1, 9'h051, 1, 1, 1, 9'h043, 2));
    tbl.push_back(v(1, 1, 9'h052, 1, 2, 0, 0, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(v(1, 1, 9'h060, 1, 0, 1, 9'h050, 3));
    tbl.push_back(v(1, 1, 9'h061, 1, 1, 1, 9'h051, 3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 2));

    repeat (2) tick();
    chk("reset out_de", out_de, 0);
    chk("reset ram_wr_en", ram_wr_en, 0);
    chk("reset line_len", line_len, 0);
    chk("reset ovf", ovf, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      set(tbl[i].vs, tbl[i].de, tbl[i].d);
      chk($sformatf("row%0d rd_clk_en", i), ram_rd_clk_en, tbl[i].rd);
      if (tbl[i].rd) chk($sformatf("row%0d rd_addr", i), ram_rd_addr, tbl[i].ra);
      tick();
      chk($sformatf("row%0d out_de", i), out_de, tbl[i].rd);
      if (tbl[i].rd) chk($sformatf("row%0d out_cur", i), out_cur, tbl[i].d);
      chk($sformatf("row%0d prev_vld", i), out_prev_vld, tbl[i].pv);
      chk($sformatf("row%0d out_prev", i), out_prev, tbl[i].prev);
      chk($sformatf("row%0d wr_en", i), ram_wr_en, tbl[i].rd);
      if (tbl[i].rd) chk($sformatf("row%0d wr_addr", i), ram_wr_addr, tbl[i].ra);
      if (tbl[i].rd) chk($sformatf("row%0d wr_data", i), ram_wr_data, tbl[i].d);
      chk($sformatf("row%0d line_len", i), line_len, tbl[i].ln);
      chk($sformatf("row%0d ovf", i), ovf, 0);
    end

    // 2049-pixel line: the last pixel overflows
    for (int i = 0; i <= 2048; i++) begin
      set(1, 1, 9'(i));
      if (i >= 2047) chk($sformatf("ovl px%0d rd_clk_en", i), ram_rd_clk_en, i == 2047);
      if (i == 2047) chk("ovl rd_addr 2047", ram_rd_addr, 2047);
      tick();
      if (i == 2047) begin
        chk("ovl wr_addr 2047", ram_wr_addr, 2047);
        chk("ovl ovf before", ovf, 0);
      end
      if (i == 2048) begin
        chk("ovl out_de", out_de, 1);
        chk("ovl prev_vld", out_prev_vld, 0);
        chk("ovl wr_en", ram_wr_en, 0);
        chk("ovl ovf set", ovf, 1);
      end
    end
    set(1, 0, 0); tick();
    chk("ovl line_len", line_len, 2048);
    chk("ovl ovf sticky", ovf, 1);
    set(0, 0, 0); tick();
    chk("ovl ovf sticky2", ovf, 1);
    set(1, 0, 0); tick();
    chk("ovl ovf cleared", ovf, 0);

    // reset asserted at column 3 of a first line
    set(0, 0, 0); tick();
    set(1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin set(0, 1, 9'h070 + 9'(i)); tick(); end
    chk("pre-rst out_de", out_de, 1);
    rst = 1'b1;
    set(0, 1, 9'h073); tick();
    rst = 1'b0;
    chk("rst out_de", out_de, 0);
    chk("rst out_cur", out_cur, 0);
    chk("rst prev_vld", out_prev_vld, 0);
    chk("rst wr_en", ram_wr_en, 0);
    chk("rst wr_addr", ram_wr_addr, 0);
    chk("rst wr_data", ram_wr_data, 0);
    chk("rst line_len", line_len, 0);
    chk("rst ovf", ovf, 0);
    set(0, 1, 9'h074);
    chk("rst rd_clk_en", ram_rd_clk_en, 0);
    chk("rst rd_addr", ram_rd_addr, 0);
    tick();
    chk("idle out_de", out_de, 0);
    set(0, 0, 0); tick();
    chk("idle line_len", line_len, 0);
    set(0, 1, 9'h075); tick();
    chk("idle out_de2", out_de, 0);
    set(1, 1, 9'h080);
    chk("vs+de rd_clk_en", ram_rd_clk_en, 1);
    chk("vs+de rd_addr", ram_rd_addr, 0);
    tick();
    chk("vs+de out_de", out_de, 1);
    chk("vs+de out_cur", out_cur, 9'h080);
    chk("vs+de prev_vld", out_prev_vld, 0);
    set(1, 0, 0); tick();
    chk("vs+de line_len", line_len, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/line_buf_ctrl.md
# line_buf_ctrl

Line-delay controller that sits directly upstream of the 2048×9 simple dual-port line RAM (`PGL_SDPRAM_11`, read latency 1, no output register). Consumes the raw pixel stream, generates all RAM write/read addresses and strobes, and re-emits each current-line pixel alongside the co-located pixel of the previous line. Its output feeds the 2-row neighbourhood stages of the processing pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, 11, RAM address width; maximum line length is 2**ADDR_WIDTH pixels.
- `DATA_WIDTH`, 9, pixel width; equals the RAM data width.

Ports:
- `clk`  in  1  sole clock; the RAM write and read clocks are tied to it.
- `rst`  in  1  reset, synchronous, active-high.
- `in_vsync`  in  1  frame sync; its rising edge starts a frame.
- `in_de`  in  1  pixel valid; a high run is one line.
- `in_data`  in  DATA_WIDTH  pixel.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_wr_addr`  out  ADDR_WIDTH  to RAM `wr_addr`.
- `ram_wr_data`  out  DATA_WIDTH  to RAM `wr_data`.
- `ram_rd_addr`  out  ADDR_WIDTH  to RAM `rd_addr`.
- `ram_rd_clk_en`  out  1  to RAM `rd_clk_en`.
- `ram_rd_data`  in  DATA_WIDTH  from RAM `rd_data`.
- `out_de`  out  1  output pixel valid.
- `out_cur`  out  DATA_WIDTH  current-line pixel.
- `out_prev`  out  DATA_WIDTH  previous-line pixel at the same column.
- `out_prev_vld`  out  1  `out_prev` is meaningful (0 on the first line of a frame).
- `line_len`  out  ADDR_WIDTH+1  length of the last completed line.
- `ovf`  out  1  sticky: a line exceeded 2**ADDR_WIDTH pixels in this frame.

## Operation
- FSM states: WAIT_FRAME, FIRST_LINE, LINES.
  - WAIT_FRAME → FIRST_LINE on a `in_vsync` rising edge; `in_de` is ignored in WAIT_FRAME.
  - FIRST_LINE → LINES on the falling edge of `in_de`.
  - A `in_vsync` rising edge in any state returns to FIRST_LINE. It clears `col` and `ovf`. If it arrives mid-line, the partial line is abandoned and `line_len` is not updated.
- Column counter `col`, ADDR_WIDTH+1 bits:
  - Increments on each accepted pixel.
  - Cleared in the cycle after each `in_de` falling edge.
  - `line_len` captures `col` on that falling edge.
- Read-ahead collision avoidance: read and write never target the same address in the same cycle.
  - In cycle t, an accepted pixel drives `ram_rd_addr = col` and `ram_rd_clk_en = 1`.
  - In cycle t+1, the pixel registered in t is written to the same address.
- Overflow: a pixel accepted when `col == 2**ADDR_WIDTH` sets `ovf`. Such pixels are not written and not read. `out_de` still asserts, with `out_prev_vld = 0`. `col` saturates.
- `out_prev_vld` = 1 only in LINES and only for columns below the previous line's `line_len`. Beyond that, the RAM content is stale.
- Reset mid-operation: the FSM goes to WAIT_FRAME, and all counters and outputs take their reset values. RAM contents are not cleared.

## Timing
- Reset values: every output is 0, including the RAM strobes and addresses.
- Latency: pixel in at cycle t → `out_de`/`out_cur`/`out_prev` at t+1. `out_prev` is taken combinationally from `ram_rd_data`, which the RAM's 1-cycle read latency makes valid at t+1.
- `ram_wr_en` asserts at t+1 with `ram_wr_addr` equal to `ram_rd_addr` of cycle t.
- Back-to-back lines with a 1-cycle `in_de` gap are supported: `col` clears in the gap cycle.
- Simultaneous `in_vsync` edge and `in_de` high: vsync wins. The pixel is treated as column 0 of the first line.
- `ovf` updates one cycle after the offending pixel.

## Structure
- Package `line_buf_pkg`:
  - FSM state enum.
  - Constants `LB_ADDR_WIDTH = 11`, `LB_DATA_WIDTH = 9`.
- One natural sub-module: `sig_edge`, a rising/falling edge detector instanced for both `in_vsync` and `in_de`.
- The RAM itself is instanced by the parent, not inside this block.

## Test plan
- Reset, then a vsync edge, then a 4-pixel line 0x010..0x013:
  - `ram_wr_addr` 0..3, each one cycle after `ram_rd_addr` 0..3.
  - `out_prev_vld = 0` throughout.
  - `line_len = 4`.
- Second line 0x020..0x023 (RAM model attached): `out_prev` = 0x010..0x013 and `out_cur` = 0x020..0x023, both at 1-cycle latency, with `out_prev_vld = 1`.
- Line of 2049 pixels:
  - Pixel 2049 sets `ovf` one cycle later, with no RAM write or read for it.
  - The next vsync edge clears `ovf`.
- Line 3 longer than line 2 (6 vs 4 pixels): `out_prev_vld` drops at column 4.
- Vsync edge at column 2 of a line:
  - FSM goes to FIRST_LINE and `col` restarts at 0.
  - `line_len` keeps its old value.
- `rst` held for 1 cycle at column 3:
  - All outputs are 0 next cycle.
  - `in_de` is ignored until a new vsync edge.
